alu_sweep_master: RTL and testbench

//  Initiator side of the ALU operand/Init/Done interface: on-chip exhaustive self-test sequencer.

---
 rtl/alu_sweep_master_if.sv | 26 ++
 rtl/alu_sweep_master.sv | 160 ++++++++++++++++
 tb/tb_alu_sweep_master.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/alu_sweep_master_if.sv
// Operand/Init/Done bus between the self-test sequencer (master) and the ALU (slave),
// plus the sequencer's status outputs.
interface alu_sweep_master_if;
    logic        start;
    logic        done;
    logic [7:0]  result;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [1:0]  select;
    logic        init;
    logic        busy;
    logic        finished;
    logic        fail;
    logic [10:0] err_count;
    logic        timeout;

    modport master (
        input  start, done, result,
        output a, b, select, init, busy, finished, fail, err_count, timeout
    );

    modport slave (
        output start, done, result,
        input  a, b, select, init, busy, finished, fail, err_count, timeout
    );
endinterface

// File: rtl/alu_sweep_master.sv
// Exhaustive ALU self-test sequencer: sweeps {select,a,b} and checks against a golden model.
// Optional macro ALU_SWEEP_STOP_ON_ERR_EN: halt on the first mismatch or timeout.
module alu_sweep_master #(
    parameter int SETTLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_sweep_master_if.master   bus
);
    localparam int TMAX = (TIMEOUT > SETTLE_CYCLES) ? TIMEOUT : SETTLE_CYCLES;
    localparam int CW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {
        IDLE, DRIVE, SETTLE, INIT_LO, WAIT_DONE, CHECK, NEXT, FINISH
    } state_t;

`ifdef ALU_SWEEP_STOP_ON_ERR_EN
    localparam bit STOP_ON_ERR = 1'b1;
`else
    localparam bit STOP_ON_ERR = 1'b0;
`endif

    state_t      state_reg, state_next;
    logic [9:0]  vec_reg, vec_next;
    logic [CW-1:0] timer_reg, timer_next;
    logic        done_reg;
    logic        busy_reg, busy_next;
    logic        finished_reg, finished_next;
    logic        fail_reg, fail_next;
    logic        timeout_reg, timeout_next;
    logic [10:0] err_reg, err_next;
    logic        init_lo;
    logic [7:0]  golden;
    logic [3:0]  op_a, op_b;

    assign op_a = vec_reg[7:4];
    assign op_b = vec_reg[3:0];

    always_comb begin
        golden = 8'h00;
        case (vec_reg[9:8])
            2'b00:   golden = {4'b0, op_a} + {4'b0, op_b};
            2'b01:   golden = ({4'b0, op_a} - {4'b0, op_b}) & 8'h1F;
            2'b10:   golden = {4'b0, op_a} * {4'b0, op_b};
            default: golden = {4'b0, op_a & op_b};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            vec_reg      <= '0;
            timer_reg    <= '0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
            finished_reg <= 1'b0;
            fail_reg     <= 1'b0;
            timeout_reg  <= 1'b0;
            err_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            vec_reg      <= vec_next;
            timer_reg    <= timer_next;
            done_reg     <= bus.done;
            busy_reg     <= busy_next;
            finished_reg <= finished_next;
            fail_reg     <= fail_next;
            timeout_reg  <= timeout_next;
            err_reg      <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        vec_next      = vec_reg;
        timer_next    = timer_reg;
        busy_next     = busy_reg;
        finished_next = finished_reg;
        fail_next     = fail_reg;
        timeout_next  = timeout_reg;
        err_next      = err_reg;
        init_lo       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    finished_next = 1'b0;
                    fail_next     = 1'b0;
                    timeout_next  = 1'b0;
                    err_next      = '0;
                    vec_next      = '0;
                    busy_next     = 1'b1;
                    state_next    = DRIVE;
                end
            end
            DRIVE: begin
                timer_next = '0;
                state_next = (vec_reg[9:8] == 2'b10) ? INIT_LO : SETTLE;
            end
            SETTLE: begin
                if (timer_reg == CW'(SETTLE_CYCLES - 1)) state_next = CHECK;
                else                                     timer_next = timer_reg + 1'b1;
            end
            INIT_LO: begin
                init_lo    = 1'b1;
                timer_next = '0;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Only a fresh rising edge counts; a Done left high by the last multiply is stale.
                if (bus.done && !done_reg) begin
                    state_next = CHECK;
                end else if (timer_reg == CW'(TIMEOUT - 1)) begin
                    err_next     = (err_reg == 11'h7FF) ? err_reg : err_reg + 1'b1;
                    fail_next    = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = STOP_ON_ERR ? FINISH : NEXT;
                end else begin
                    timer_next = timer_reg + 1'b1;
                end
            end
            CHECK: begin
                state_next = NEXT;
                if (bus.result != golden) begin
                    err_next  = (err_reg == 11'h7FF) ? err_reg : err_reg + 1'b1;
                    fail_next = 1'b1;
                    if (STOP_ON_ERR) state_next = FINISH;
                end
            end
            NEXT: begin
                if (vec_reg == 10'h3FF) begin
                    state_next = FINISH;
                end else begin
                    vec_next   = vec_reg + 1'b1;
                    state_next = DRIVE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Finished rises on entry to FINISH so a same-cycle Start lands outside IDLE.
        if (state_next == FINISH && state_reg != FINISH) begin
            finished_next = 1'b1;
            busy_next     = 1'b0;
        end
    end

    assign bus.a         = op_a;
    assign bus.b         = op_b;
    assign bus.select    = vec_reg[9:8];
    assign bus.init      = ~init_lo;
    assign bus.busy      = busy_reg;
    assign bus.finished  = finished_reg;
    assign bus.fail      = fail_reg;
    assign bus.err_count = err_reg;
    assign bus.timeout   = timeout_reg;
endmodule

// File: tb/tb_alu_sweep_master.sv
// Directed bench: behavioural ALU with fault knobs drives full sweeps of alu_sweep_master.
module tb_alu_sweep_master;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_sweep_master_if bus ();

    alu_sweep_master #(.SETTLE_CYCLES(2), .TIMEOUT(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int init_pulses = 0;

    // ALU knobs: done_mode 0 = normal (latency 3), 1 = never, 2 = stuck high
    int   done_mode = 0;
    logic corrupt   = 1'b0;
    logic done_q;
    int   lat_cnt;

    always_comb begin
        case (bus.select)
            2'b00:   bus.result = {4'b0, bus.a} + {4'b0, bus.b};
            2'b01:   bus.result = ({4'b0, bus.a} - {4'b0, bus.b}) & 8'h1F;
            2'b10:   bus.result = {4'b0, bus.a} * {4'b0, bus.b};
            default: bus.result = {4'b0, bus.a & bus.b};
        endcase
        if (corrupt && bus.select == 2'b00 && bus.a == 4'd3 && bus.b == 4'd4)
            bus.result = 8'd8;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q  <= 1'b0;
            lat_cnt <= 0;
        end else if (!bus.init) begin
            done_q  <= 1'b0;
            lat_cnt <= 3;
        end else if (lat_cnt != 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) done_q <= 1'b1;
        end
    end

    assign bus.done = (done_mode == 2) ? 1'b1 : (done_mode == 1) ? 1'b0 : done_q;

    always @(posedge clk) if (rst_n && !bus.init) init_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse Start, then wait (bounded) for Finished; optionally re-pulse Start mid-sweep.
    task automatic run_sweep(input string tag, input bit inject);
        init_pulses = 0;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        check({tag, "_busy_after_start"}, bus.busy, 1);
        check({tag, "_finished_cleared"}, bus.finished, 0);
        check({tag, "_err_cleared"}, bus.err_count, 0);
        for (int i = 0; i < 30000 && !bus.finished; i++) begin
            bus.start = (inject && i == 3000);
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_finished"}, bus.finished, 1);
        check({tag, "_busy_low"}, bus.busy, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        #12;
        check("rst_a", bus.a, 0);
        check("rst_b", bus.b, 0);
        check("rst_select", bus.select, 0);
        check("rst_init", bus.init, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_finished", bus.finished, 0);
        check("rst_fail", bus.fail, 0);
        check("rst_err", bus.err_count, 0);
        check("rst_timeout", bus.timeout, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Ideal ALU, with a Start pulse injected mid-sweep that must be ignored
        run_sweep("ideal", 1'b1);
        $display("ideal sweep: err=%0d fail=%0b init_pulses=%0d", bus.err_count, bus.fail, init_pulses);
        check("ideal_fail", bus.fail, 0);
        check("ideal_err", bus.err_count, 0);
        check("ideal_timeout", bus.timeout, 0);
        check("ideal_init_pulses", init_pulses, 256);
        check("ideal_last_vec", {bus.select, bus.a, bus.b}, 10'h3FF);

        // Corrupted add 3+4
        corrupt = 1'b1;
        run_sweep("corrupt", 1'b0);
        corrupt = 1'b0;
        $display("corrupt sweep: err=%0d fail=%0b vec=%0h", bus.err_count, bus.fail, {bus.select, bus.a, bus.b});
        check("corrupt_fail", bus.fail, 1);
        check("corrupt_err", bus.err_count, 1);
`ifdef ALU_SWEEP_STOP_ON_ERR_EN
        check("corrupt_stop_vec", {bus.select, bus.a, bus.b}, 10'h034);
`else
        check("corrupt_last_vec", {bus.select, bus.a, bus.b}, 10'h3FF);
        check("corrupt_init_pulses", init_pulses, 256);
`endif

        // Done never rises
        done_mode = 1;
        run_sweep("nodone", 1'b0);
        $display("nodone sweep: err=%0d timeout=%0b", bus.err_count, bus.timeout);
        check("nodone_timeout", bus.timeout, 1);
        check("nodone_fail", bus.fail, 1);
`ifdef ALU_SWEEP_STOP_ON_ERR_EN
        check("nodone_err", bus.err_count, 1);
`else
        check("nodone_err", bus.err_count, 256);
`endif

        // Done stuck high: no edge, every multiply times out
        done_mode = 2;
        run_sweep("stuck", 1'b0);
        $display("stuck sweep: err=%0d timeout=%0b", bus.err_count, bus.timeout);
        check("stuck_timeout", bus.timeout, 1);
`ifdef ALU_SWEEP_STOP_ON_ERR_EN
        check("stuck_err", bus.err_count, 1);
`else
        check("stuck_err", bus.err_count, 256);
`endif

        // Asynchronous reset while waiting for Done
        done_mode = 1;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        for (int i = 0; i < 5000 && bus.init; i++) @(negedge clk);
        check("wait_init_seen", bus.init, 0);
        repeat (3) @(posedge clk);
        #2;
        check("wait_busy", bus.busy, 1);
        check("wait_init_high", bus.init, 1);
        rst_n = 1'b0;
        #1;
        $display("reset in WAIT_DONE: init=%0b busy=%0b err=%0d", bus.init, bus.busy, bus.err_count);
        check("arst_init", bus.init, 1);
        check("arst_busy", bus.busy, 0);
        check("arst_err", bus.err_count, 0);
        check("arst_select", bus.select, 0);
        check("arst_finished", bus.finished, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
